// File: rtl/pipe_skid_buf.sv
// Two-entry pipeline skid buffer: the main register drives the outputs and the skid register
// catches the beat in flight when downstream stalls. Defining SKID_FLUSH_EN adds a flush input.
module pipe_skid_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SKID_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [FLAG_W-1:0] in_flags,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [FLAG_W-1:0] out_flags,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [FLAG_W-1:0] main_flags_q, skid_flags_q;

    logic load_main;
    logic load_skid;
    logic move_skid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (in_valid) begin
                    load_main = 1'b1;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                if (in_valid && out_ready) begin
                    load_main = 1'b1;
                end else if (in_valid) begin
                    load_skid = 1'b1;
                    state_d   = StFull;
                end else if (out_ready) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_ready) begin
                    move_skid = 1'b1;
                    state_d   = StBusy;
                end
            end
            default: state_d = StEmpty;
        endcase
`ifdef SKID_FLUSH_EN
        // Flush beats every transfer: drop held beats and the offered one, keep data registers.
        if (flush) begin
            state_d   = StEmpty;
            load_main = 1'b0;
            load_skid = 1'b0;
            move_skid = 1'b0;
        end
`endif
    end

    always_comb begin
        out_valid = (state_q != StEmpty);
        in_ready  = (state_q != StFull);
        unique case (state_q)
            StBusy:  occupancy = 2'd1;
            StFull:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_data_q  <= '0;
            main_flags_q <= '0;
            skid_data_q  <= '0;
            skid_flags_q <= '0;
        end else begin
            if (load_main) begin
                main_data_q  <= in_data;
                main_flags_q <= in_flags;
            end else if (move_skid) begin
                main_data_q  <= skid_data_q;
                main_flags_q <= skid_flags_q;
            end
            if (load_skid) begin
                skid_data_q  <= in_data;
                skid_flags_q <= in_flags;
            end
        end
    end

    assign out_data  = main_data_q;
    assign out_flags = main_flags_q;

endmodule

// File: doc/pipe_skid_buf.md
PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

Interface
REQ-001 Parameter: DATA_W, default 32, payload width.
REQ-002 Parameter: FLAG_W, default 4, status-flag width carried with each payload.
REQ-003 Single clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  clock; all state updates on posedge.
REQ-005 Port: rst  input  1  asynchronous reset, active-low (asserted at 0).
REQ-006 Port: in_valid  input  1  upstream offers a beat.
REQ-007 Port: in_data  input  DATA_W  upstream payload.
REQ-008 Port: in_flags  input  FLAG_W  upstream flags.
REQ-009 Port: in_ready  output  1  buffer can accept a beat this cycle.
REQ-010 Port: out_valid  output  1  buffer presents a beat.
REQ-011 Port: out_data  output  DATA_W  presented payload.
REQ-012 Port: out_flags  output  FLAG_W  presented flags.
REQ-013 Port: out_ready  input  1  downstream accepts presented beat.
REQ-014 Port: occupancy  output  2  number of held beats (0..2).

Function
REQ-015 Beat transfers upstream when in_valid & in_ready at posedge; downstream when out_valid & out_ready at posedge.
REQ-016 Storage: main register (drives out_data/out_flags) plus one skid register; state machine EMPTY, BUSY, FULL.
REQ-017 EMPTY: in_valid -> load main, go BUSY; else stay.
REQ-018 BUSY: in_valid & out_ready -> load main with new beat, stay BUSY; in_valid & !out_ready -> load skid, go FULL; !in_valid & out_ready -> EMPTY; neither -> stay.
REQ-019 FULL: out_ready -> move skid to main, go BUSY; else stay; no upstream beat accepted.
REQ-020 out_valid = (state != EMPTY); in_ready = (state != FULL); both decoded from registered state only, never from in_valid/out_ready combinationally.
REQ-021 occupancy = 0/1/2 for EMPTY/BUSY/FULL.
REQ-022 Latency: beat accepted at edge N is presented on out_* from edge N (visible cycle N+1) when buffer was EMPTY.
REQ-023 Ordering strictly FIFO; no beat dropped or duplicated under any in_valid/out_ready pattern.
REQ-024 out_data/out_flags hold value while out_valid & !out_ready.
REQ-025 Data registers not updated when no transfer occurs; stale contents when EMPTY are don't-care but stable.

Reset
REQ-026 rst low forces immediately: state EMPTY, main and skid registers 0, out_valid 0, out_data 0, out_flags 0, occupancy 0, in_ready 1.
REQ-027 Reset mid-operation discards all held beats; no transfer is counted on the edge where rst is low.
REQ-028 First accepted beat possible on first posedge with rst high.

Configuration
REQ-029 Macro SKID_FLUSH_EN defined: adds input port flush (1 bit); flush high at posedge forces state EMPTY, discards held beats and any beat offered that cycle, data registers unchanged; flush has priority over all transfers.
REQ-030 SKID_FLUSH_EN undefined: no flush port; behaviour exactly REQ-015..REQ-028.

Verification
REQ-031 Reset then in_valid=1, in_data=0x0000_00A5, in_flags=0x3, out_ready=1 -> next cycle out_valid=1, out_data=0x0000_00A5, out_flags=0x3, occupancy=1.
REQ-032 out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0, out_data=0x11; third beat 0x33 held upstream; raise out_ready -> outputs 0x11, 0x22, 0x33 in order over 3 cycles.
REQ-033 Continuous in_valid=1 and out_ready=1, data 1..100 -> 100 beats out in order, one per cycle, occupancy stays 1.
REQ-034 Random in_valid/out_ready toggling, 10000 beats -> scoreboard shows no loss, duplication or reordering; out_data stable while stalled.
REQ-035 Hold FULL (0xAA, 0xBB), assert rst low mid-cycle -> out_valid=0, occupancy=0, in_ready=1, out_data=0 before next posedge.
REQ-036 With SKID_FLUSH_EN: FULL state, flush=1 with in_valid=1, in_data=0xCC -> next cycle out_valid=0, occupancy=0; 0xCC never appears on output.
